// File: rtl/had_pkg.sv
// Shared constants, coefficient array types and helpers for the 4x4
// Hadamard SATD block (had).
package had_pkg;

    localparam int PIX_W   = 8;
    localparam int DIFF_W  = 9;
    localparam int HCOEF_W = 11;
    localparam int VCOEF_W = 13;
    localparam int SUM_W   = 16;
    localparam int N       = 4;

    typedef logic signed [DIFF_W-1:0]  diff4x4_t  [N][N];
    typedef logic signed [HCOEF_W-1:0] hcoef4x4_t [N][N];
    typedef logic signed [VCOEF_W-1:0] coef4x4_t  [N][N];

    // Magnitude of a final coefficient. The most negative 13-bit value can
    // never occur (|coef| <= 16*255), so negation cannot overflow.
    function automatic logic [VCOEF_W-1:0] coef_abs(input logic signed [VCOEF_W-1:0] v);
        logic [VCOEF_W-1:0] r;
        if (v[VCOEF_W-1]) begin
            r = VCOEF_W'(-v);
        end else begin
            r = VCOEF_W'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/had_butterfly4.sv
// 4-point Hadamard butterfly, purely combinational. Output grows by two
// bits over the input so that no sum of four terms can overflow.
module had_butterfly4 #(
    parameter int IN_W = 9
) (
    input  logic signed [IN_W-1:0] a0_i,
    input  logic signed [IN_W-1:0] a1_i,
    input  logic signed [IN_W-1:0] a2_i,
    input  logic signed [IN_W-1:0] a3_i,
    output logic signed [IN_W+1:0] b0_o,
    output logic signed [IN_W+1:0] b1_o,
    output logic signed [IN_W+1:0] b2_o,
    output logic signed [IN_W+1:0] b3_o
);

    localparam int OUT_W = IN_W + 2;

    logic signed [OUT_W-1:0] x0_s, x1_s, x2_s, x3_s;
    logic signed [OUT_W-1:0] s01_s, d01_s, s23_s, d23_s;

    assign x0_s = OUT_W'(a0_i);
    assign x1_s = OUT_W'(a1_i);
    assign x2_s = OUT_W'(a2_i);
    assign x3_s = OUT_W'(a3_i);

    // Pairwise sums/differences shared by all four outputs.
    assign s01_s = x0_s + x1_s;
    assign d01_s = x0_s - x1_s;
    assign s23_s = x2_s + x3_s;
    assign d23_s = x2_s - x3_s;

    assign b0_o = s01_s + s23_s;   // a0+a1+a2+a3
    assign b1_o = d01_s + d23_s;   // a0-a1+a2-a3
    assign b2_o = s01_s - s23_s;   // a0+a1-a2-a3
    assign b3_o = d01_s - d23_s;   // a0-a1-a2+a3

endmodule

// File: rtl/had.sv
// 4x4 Hadamard SATD, three pipeline stages (diffs, horizontal coefficients,
// final sum) advancing on en, plus an export register loaded on
// export_data_had. Define HAD_NORM_EN to store (sum+1)>>1 in the last stage
// instead of the raw sum.
module had
    import had_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        export_data_had,
    input  logic [31:0] a4x4_ref_blk1,
    input  logic [31:0] a4x4_ref_blk2,
    input  logic [31:0] a4x4_ref_blk3,
    input  logic [31:0] a4x4_ref_blk4,
    input  logic [31:0] a4x4_cur_blk1,
    input  logic [31:0] a4x4_cur_blk2,
    input  logic [31:0] a4x4_cur_blk3,
    input  logic [31:0] a4x4_cur_blk4,
    output logic [15:0] had_4x4
);

    logic [31:0]      cur_row_s [N];
    logic [31:0]      ref_row_s [N];

    diff4x4_t         diff_d;
    diff4x4_t         diff_q;
    hcoef4x4_t        hcoef_d;
    hcoef4x4_t        hcoef_q;
    coef4x4_t         vcoef_s;
    logic [SUM_W-1:0] sum_s;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] had_q;

    assign cur_row_s[0] = a4x4_cur_blk1;
    assign cur_row_s[1] = a4x4_cur_blk2;
    assign cur_row_s[2] = a4x4_cur_blk3;
    assign cur_row_s[3] = a4x4_cur_blk4;
    assign ref_row_s[0] = a4x4_ref_blk1;
    assign ref_row_s[1] = a4x4_ref_blk2;
    assign ref_row_s[2] = a4x4_ref_blk3;
    assign ref_row_s[3] = a4x4_ref_blk4;

    // Per-pixel signed difference cur - ref, zero-extending both to 9 bits.
    always_comb begin
        diff_d = '{default: '0};
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                diff_d[r][c] = {1'b0, cur_row_s[r][PIX_W*c +: PIX_W]}
                             - {1'b0, ref_row_s[r][PIX_W*c +: PIX_W]};
            end
        end
    end

    // Horizontal pass: one butterfly per registered diff row.
    for (genvar r = 0; r < N; r++) begin : g_hor
        had_butterfly4 #(.IN_W(DIFF_W)) u_bf (
            .a0_i (diff_q[r][0]),
            .a1_i (diff_q[r][1]),
            .a2_i (diff_q[r][2]),
            .a3_i (diff_q[r][3]),
            .b0_o (hcoef_d[r][0]),
            .b1_o (hcoef_d[r][1]),
            .b2_o (hcoef_d[r][2]),
            .b3_o (hcoef_d[r][3])
        );
    end

    // Vertical pass: one butterfly per column of registered coefficients.
    for (genvar c = 0; c < N; c++) begin : g_ver
        had_butterfly4 #(.IN_W(HCOEF_W)) u_bf (
            .a0_i (hcoef_q[0][c]),
            .a1_i (hcoef_q[1][c]),
            .a2_i (hcoef_q[2][c]),
            .a3_i (hcoef_q[3][c]),
            .b0_o (vcoef_s[0][c]),
            .b1_o (vcoef_s[1][c]),
            .b2_o (vcoef_s[2][c]),
            .b3_o (vcoef_s[3][c])
        );
    end

    // Sum of absolute coefficients; bounded by 16*4080 so 16 bits suffice.
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sum_s = sum_s + SUM_W'(coef_abs(vcoef_s[r][c]));
            end
        end
    end

`ifdef HAD_NORM_EN
    // Rounded halving; sum_s never exceeds 65280 so the +1 cannot wrap.
    assign sum_d = (sum_s + 16'd1) >> 1;
`else
    assign sum_d = sum_s;
`endif

    // Pipeline stages S1..S3, all gated by en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    diff_q[r][c]  <= {DIFF_W{1'b0}};
                    hcoef_q[r][c] <= {HCOEF_W{1'b0}};
                end
            end
            sum_q <= {SUM_W{1'b0}};
        end else if (en) begin
            diff_q  <= diff_d;
            hcoef_q <= hcoef_d;
            sum_q   <= sum_d;
        end
    end

    // Export register: captures the pre-edge S3 value regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            had_q <= {SUM_W{1'b0}};
        end else if (export_data_had) begin
            had_q <= sum_q;
        end
    end

    assign had_4x4 = had_q;

endmodule

// File: tb/tb_had.sv
// Self-checking bench for had: a vector table, directed multi-cycle
// sequences and a randomized stream against a matrix-form SATD model.
module tb_had;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             export_data_had;
    logic [3:0][31:0] cur_v;
    logic [3:0][31:0] ref_v;
    logic [15:0]      had_4x4;

    int checks = 0;
    int errors = 0;

    // Model: SATD value of the vector currently held in each stage.
    int s1_m = 0, s2_m = 0, s3_m = 0, had_m = 0;

    typedef struct {
        logic [3:0][31:0] cur;
        logic [3:0][31:0] refr;
        int               exp;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    had dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .export_data_had (export_data_had),
        .a4x4_ref_blk1   (ref_v[0]),
        .a4x4_ref_blk2   (ref_v[1]),
        .a4x4_ref_blk3   (ref_v[2]),
        .a4x4_ref_blk4   (ref_v[3]),
        .a4x4_cur_blk1   (cur_v[0]),
        .a4x4_cur_blk2   (cur_v[1]),
        .a4x4_cur_blk3   (cur_v[2]),
        .a4x4_cur_blk4   (cur_v[3]),
        .had_4x4         (had_4x4)
    );

    function automatic int norm(input int x);
`ifdef HAD_NORM_EN
        return (x + 1) / 2;
`else
        return x;
`endif
    endfunction

    // Entry (u,i) of the natural-order 4x4 Hadamard matrix.
    function automatic int hs(input int u, input int i);
        return ($countones(u & i) % 2 == 1) ? -1 : 1;
    endfunction

    // SATD = sum |H * D * H^T|, computed directly as a matrix product.
    function automatic int satd(input logic [3:0][31:0] cu, input logic [3:0][31:0] rf);
        int d[4][4];
        int t;
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                d[i][j] = int'(cu[i][8*j +: 8]) - int'(rf[i][8*j +: 8]);
        for (int u = 0; u < 4; u++) begin
            for (int v = 0; v < 4; v++) begin
                t = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        t += hs(u, i) * hs(v, j) * d[i][j];
                s += (t < 0) ? -t : t;
            end
        end
        return norm(s);
    endfunction

    function automatic logic [3:0][31:0] rand_vec();
        logic [3:0][31:0] v;
        for (int r = 0; r < 4; r++) v[r] = $urandom;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One rising edge with the model updated from pre-edge values; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            s1_m = 0; s2_m = 0; s3_m = 0; had_m = 0;
        end else begin
            if (export_data_had) had_m = s3_m;
            if (en) begin
                s3_m = s2_m;
                s2_m = s1_m;
                s1_m = satd(cur_v, ref_v);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0][31:0] va, vb, vc, vx;
        int q[$];
        int last;
        int xa, xb, xc;

        rst_n = 1'b1; en = 1'b0; export_data_had = 1'b0;
        cur_v = '0; ref_v = '0;
        #1 rst_n = 1'b0;
        #1 check("reset_async", int'(had_4x4), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_hold", int'(had_4x4), 0);

        // Vector table
        va = rand_vec();
        tbl[0] = '{cur: '0, refr: '0, exp: 0};
        tbl[1] = '{cur: va, refr: va, exp: 0};
        tbl[2] = '{cur: {4{32'h01010101}}, refr: '0, exp: norm(16)};
        tbl[3] = '{cur: {4{32'hFFFFFFFF}}, refr: '0, exp: norm(4080)};
        tbl[4] = '{cur: '0, refr: {4{32'hFFFFFFFF}}, exp: norm(4080)};
        tbl[5] = '{cur: {32'h0, 32'h0, 32'h0, 32'h00000001}, refr: '0, exp: norm(16)};
        tbl[6] = '{cur: {32'hFF00FF00, 32'h00FF00FF, 32'hFF00FF00, 32'h00FF00FF},
                   refr: '0, exp: norm(4080)};
        vb = rand_vec();
        vc = rand_vec();
        tbl[7] = '{cur: vb, refr: vc, exp: satd(vb, vc)};

        for (int k = 0; k < 8; k++) begin
            cur_v = tbl[k].cur; ref_v = tbl[k].refr;
            en = 1'b1; export_data_had = 1'b0;
            tick(); tick(); tick();
            en = 1'b0; export_data_had = 1'b1;
            tick();
            export_data_had = 1'b0;
            check($sformatf("table_%0d", k), int'(had_4x4), tbl[k].exp);
        end

        // Vector every 3 cycles, export pulse on the edge that applies the next one
        en = 1'b1;
        last = int'(had_4x4);
        for (int n = 0; n <= 10; n++) begin
            cur_v = rand_vec(); ref_v = rand_vec();
            if (n == 10) begin
                cur_v = '0; ref_v = '0;
            end
            export_data_had = (n > 0);
            tick();
            if (n > 0) begin
                last = q.pop_front();
                check("stream_export", int'(had_4x4), last);
            end
            q.push_back(satd(cur_v, ref_v));
            export_data_had = 1'b0;
            cur_v = rand_vec(); ref_v = rand_vec();
            tick();
            check("stream_hold1", int'(had_4x4), last);
            tick();
            check("stream_hold2", int'(had_4x4), last);
        end

        // Hold with en=0, then drain with en and export together
        va = rand_vec(); vb = rand_vec(); vc = rand_vec(); vx = rand_vec();
        xa = satd(va, vx); xb = satd(vb, vx); xc = satd(vc, vx);
        en = 1'b1; export_data_had = 1'b0; ref_v = vx;
        cur_v = va; tick();
        cur_v = vb; tick();
        cur_v = vc; tick();
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cur_v = rand_vec(); ref_v = rand_vec();
            tick();
        end
        export_data_had = 1'b1;
        tick();
        check("hold_s3", int'(had_4x4), xa);
        en = 1'b1;
        tick();
        check("both_s3", int'(had_4x4), xa);
        tick();
        check("both_s2", int'(had_4x4), xb);
        tick();
        check("both_s1", int'(had_4x4), xc);
        export_data_had = 1'b0;

        // Asynchronous reset in the middle of a stream
        en = 1'b1; export_data_had = 1'b1;
        cur_v = {4{32'hFFFFFFFF}}; ref_v = '0;
        tick(); tick(); tick(); tick();
        check("pre_reset", int'(had_4x4), norm(4080));
        #2 rst_n = 1'b0;
        #1 check("mid_reset_async", int'(had_4x4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        s1_m = 0; s2_m = 0; s3_m = 0; had_m = 0;
        en = 1'b0; export_data_had = 1'b1;
        tick();
        check("post_reset_export", int'(had_4x4), 0);
        va = rand_vec(); vb = rand_vec();
        cur_v = va; ref_v = vb;
        en = 1'b1; export_data_had = 1'b0;
        tick(); tick(); tick();
        en = 1'b0; export_data_had = 1'b1;
        tick();
        check("refill", int'(had_4x4), satd(va, vb));

        // Randomized en/export/data stream against the model
        for (int n = 0; n < 300; n++) begin
            en = ($urandom_range(0, 9) < 7);
            export_data_had = ($urandom_range(0, 9) < 4);
            cur_v = rand_vec();
            ref_v = ($urandom_range(0, 3) == 0) ? cur_v : rand_vec();
            tick();
            check("fuzz", int'(had_4x4), had_m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/had.md
HAD -- requirements
Module: had

Interface
REQ-001 SHALL have parameter-free ports; clock `clk`, reset `rst_n` (one clock; reset is asynchronous and active-low).
REQ-002 SHALL have ports, in this order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  pipeline advance enable
- export_data_had  input  1  load result into output register
- a4x4_ref_blk1..a4x4_ref_blk4  input  32 each  reference rows 0..3
- a4x4_cur_blk1..a4x4_cur_blk4  input  32 each  current rows 0..3
- had_4x4  output  16  registered SATD result
REQ-003 SHALL treat each row word as four unsigned 8-bit pixels, column c in bits [8c+7:8c].

Function
REQ-004 SHALL compute the 4x4 Hadamard SATD of diff = cur - ref, with each diff a 9-bit signed value.
REQ-005 SHALL use the 1-D 4-point butterfly b0=a0+a1+a2+a3, b1=a0-a1+a2-a3, b2=a0+a1-a2-a3, b3=a0-a1-a2+a3.
REQ-006 SHALL apply the butterfly horizontally on each row (11-bit signed), then vertically on each column (13-bit signed).
REQ-007 SHALL sum the absolute values of all 16 coefficients into a 16-bit unsigned value (max 65280, no overflow).
REQ-008 SHALL be a 3-stage pipeline; all stage registers advance only on a rising edge with en=1 and hold when en=0:
- S1: registered diffs
- S2: registered horizontal coefficients
- S3: registered final (normalized) sum
REQ-009 Latency: inputs sampled at edge k (en=1) SHALL appear in S3 after edge k+2 if en stays 1.
REQ-010 had_4x4 SHALL load S3 on a rising edge with export_data_had=1, independent of en, and SHALL hold otherwise.
REQ-011 When en and export_data_had are both 1 on the same edge, had_4x4 SHALL take the pre-edge S3 value while S3 advances.
REQ-012 SHALL not check for X on unused cycles; no valid handshake exists beyond en/export_data_had.

Reset
REQ-013 rst_n=0 SHALL asynchronously clear S1, S2, S3 and had_4x4 to 0.
REQ-014 Reset mid-pipeline SHALL discard all in-flight data; the first export after reset without new en cycles SHALL yield 0.

Configuration
REQ-015 With HAD_NORM_EN defined, S3 SHALL hold (sum+1)>>1 (VVC SATD normalization).
REQ-016 Without HAD_NORM_EN, S3 SHALL hold the raw 16-bit sum.

Structure
REQ-017 Package had_pkg SHALL hold PIX_W=8, DIFF_W=9, HCOEF_W=11, VCOEF_W=13, SUM_W=16, and a typedef for a 4x4 array of coefficients.
REQ-018 The 4-point butterfly SHALL be sub-module had_butterfly4 (input width parameterized), instantiated 4x horizontally and 4x vertically.

Verification
REQ-019 cur=ref=random, en=1, export after 3 cycles -> had_4x4=0.
REQ-020 All cur rows 0x01010101, all ref 0 -> DC only -> 8 with HAD_NORM_EN, 16 without.
REQ-021 All cur 0xFFFFFFFF, all ref 0 -> 2040 with HAD_NORM_EN, 4080 without.
REQ-022 Vectors applied every 3 cycles with export pulse every 3rd cycle -> each export yields the SATD of the vector applied 3 edges earlier; had_4x4 holds between pulses.
REQ-023 en=0 for 5 cycles with changing inputs -> S1..S3 unchanged; export returns the previous S3 value.
REQ-024 rst_n asserted mid-stream -> had_4x4=0 immediately (asynchronous); pipeline refills correctly after release.
